// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types, default widths and helpers for the FIR MAC block
package fir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_MAC,
    ST_OUT,
    ST_ERR
  } fir_state_t;

  localparam int DEF_NUM_TAPS = 4;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_COEF_W   = 16;
  localparam int DEF_ACC_W    = 36;
  localparam int DEF_OUT_W    = 16;

  // Bits needed to count v distinct values; never less than one.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  localparam longint SAT_MAX = sat_max(DEF_OUT_W);

endpackage

// File: rtl/fir_filter_mac_if.sv
// rtl/fir_filter_mac_if.sv - sample/coefficient inputs and result outputs of the FIR block
interface fir_filter_mac_if
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int OUT_W  = DEF_OUT_W
);
  logic [DATA_W-1:0] sample_data;
  logic [COEF_W-1:0] fir_coefficient;
  logic              data_ready;
  logic              load_coeff;
  logic              modwait;
  logic [OUT_W-1:0]  fir_out;
  logic              fir_valid;
  logic              block_done;
  logic              err;

  modport master (
    output sample_data, fir_coefficient, data_ready, load_coeff,
    input  modwait, fir_out, fir_valid, block_done, err
  );

  modport slave (
    input  sample_data, fir_coefficient, data_ready, load_coeff,
    output modwait, fir_out, fir_valid, block_done, err
  );
endinterface

// File: rtl/fir_mac_dp.sv
// rtl/fir_mac_dp.sv - coefficient regs, delay line, accumulator and saturating magnitude
module fir_mac_dp
  import fir_pkg::*;
#(
  parameter int NUM_TAPS  = DEF_NUM_TAPS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int OUT_SHIFT = 15,
  parameter int TAP_W     = clog2(NUM_TAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift,
  input  logic              clear,
  input  logic              mac_en,
  input  logic              load,
  input  logic              out_load,
  input  logic [TAP_W-1:0]  tap,
  input  logic [TAP_W-1:0]  cidx,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [COEF_W-1:0] coef_in,
  output logic              ovf,
  output logic [OUT_W-1:0]  fir_out
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [ACC_W-1:0] SAT = ACC_W'(sat_max(OUT_W));

  logic signed [COEF_W-1:0] coef [NUM_TAPS];
  logic signed [DATA_W-1:0] dly  [NUM_TAPS];
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc, acc_next, prod_ext, shifted;
  logic        [ACC_W-1:0]  mag;
  logic        [OUT_W-1:0]  sat_out;

  // The result is taken from acc_next so fir_out is ready in the same cycle fir_valid rises.
  always_comb begin
    prod     = PROD_W'(dly[tap]) * PROD_W'(coef[tap]);
    prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    acc_next = acc + prod_ext;
    ovf      = mac_en && (acc[ACC_W-1] == prod_ext[ACC_W-1])
                      && (acc_next[ACC_W-1] != acc[ACC_W-1]);
    shifted  = acc_next >>> OUT_SHIFT;
    mag      = shifted[ACC_W-1] ? -shifted : shifted;
    sat_out  = (mag > SAT) ? '1 : mag[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        coef[i] <= '0;
        dly[i]  <= '0;
      end
      acc     <= '0;
      fir_out <= '0;
    end else begin
      if (load) coef[cidx] <= coef_in;
      if (shift) begin
        dly[0] <= sample_data;
        for (int i = 1; i < NUM_TAPS; i++) dly[i] <= dly[i-1];
      end
      if (clear)       acc <= '0;
      else if (mac_en) acc <= acc_next;
      if (out_load) fir_out <= sat_out;
    end
  end

endmodule

// File: rtl/fir_filter_mac.sv
// rtl/fir_filter_mac.sv - FIR top: strobe sync/edge detect, sequencing FSM, block counter, error flag
module fir_filter_mac
  import fir_pkg::*;
#(
  parameter int NUM_TAPS  = DEF_NUM_TAPS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int OUT_SHIFT = 15,
  parameter int BLOCK_LEN = 1000,
  parameter int SYNC_IN   = 1
) (
  input logic             clk,
  input logic             reset,
  fir_filter_mac_if.slave bus
);
  localparam int TAP_W = clog2(NUM_TAPS);
  localparam int CNT_W = clog2(BLOCK_LEN);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

  fir_state_t state, state_nxt;
  logic dr_s, lc_s, dr_q, lc_q, dr_edge, lc_edge;
  logic [TAP_W-1:0] tap, cidx;
  logic [CNT_W-1:0] cnt;
  logic coef_ok, err_q, err_set, ovf;
  logic busy, do_load, do_shift, do_mac, do_out_load, valid;

  generate
    if (SYNC_IN != 0) begin : g_sync
      logic [1:0] dr_ff, lc_ff;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dr_ff <= '0;
          lc_ff <= '0;
        end else begin
          dr_ff <= {dr_ff[0], bus.data_ready};
          lc_ff <= {lc_ff[0], bus.load_coeff};
        end
      end
      assign dr_s = dr_ff[1];
      assign lc_s = lc_ff[1];
    end else begin : g_nosync
      assign dr_s = bus.data_ready;
      assign lc_s = bus.load_coeff;
    end
  endgenerate

  assign dr_edge = dr_s & ~dr_q;
  assign lc_edge = lc_s & ~lc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (lc_edge)      state_nxt = ST_LOAD;
        else if (dr_edge) state_nxt = coef_ok ? ST_SHIFT : ST_ERR;
      end
      ST_LOAD:  state_nxt = ST_IDLE;
      ST_SHIFT: state_nxt = ST_MAC;
      ST_MAC: begin
        if (ovf)                  state_nxt = ST_ERR;
        else if (tap == LAST_TAP) state_nxt = ST_OUT;
      end
      ST_OUT:  state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy           = (state != ST_IDLE);
    do_load        = (state == ST_LOAD);
    do_shift       = (state == ST_SHIFT);
    do_mac         = (state == ST_MAC);
    valid          = (state == ST_OUT);
    do_out_load    = do_mac && (tap == LAST_TAP) && !ovf;
    bus.modwait    = busy;
    bus.fir_valid  = valid;
    bus.block_done = valid && (cnt == LAST_CNT);
    bus.err        = err_q;
  end

  // Any strobe edge that is not accepted (busy, or losing the IDLE tie to load_coeff) is an error.
  assign err_set = (state == ST_ERR) || (busy && (dr_edge || lc_edge))
                || ((state == ST_IDLE) && dr_edge && lc_edge);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dr_q    <= 1'b0;
      lc_q    <= 1'b0;
      tap     <= '0;
      cidx    <= '0;
      cnt     <= '0;
      coef_ok <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      dr_q <= dr_s;
      lc_q <= lc_s;
      if (do_shift)    tap <= '0;
      else if (do_mac) tap <= tap + 1'b1;
      if (do_load) begin
        cidx <= (cidx == LAST_TAP) ? '0 : cidx + 1'b1;
        if (cidx == LAST_TAP) coef_ok <= 1'b1;
      end
      if (valid) cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
      if (err_set)    err_q <= 1'b1;
      else if (valid) err_q <= 1'b0;
    end
  end

  fir_mac_dp #(
    .NUM_TAPS (NUM_TAPS),
    .DATA_W   (DATA_W),
    .COEF_W   (COEF_W),
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W),
    .OUT_SHIFT(OUT_SHIFT),
    .TAP_W    (TAP_W)
  ) u_dp (
    .clk        (clk),
    .reset      (reset),
    .shift      (do_shift),
    .clear      (do_shift),
    .mac_en     (do_mac),
    .load       (do_load),
    .out_load   (do_out_load),
    .tap        (tap),
    .cidx       (cidx),
    .sample_data(bus.sample_data),
    .coef_in    (bus.fir_coefficient),
    .ovf        (ovf),
    .fir_out    (bus.fir_out)
  );

endmodule
